// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package fetch_unit_pkg;

   localparam int          WORD_SIZE = 16;
   localparam logic [15:0] RESET_PC  = 16'h0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      FULL    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read handshake between the fetch stage (master) and memory (slave).
interface fetch_unit_if #(
   parameter int WORD_SIZE = 16
);

   logic                 i_readM;
   logic [WORD_SIZE-1:0] i_address;
   logic [WORD_SIZE-1:0] i_data;
   logic                 i_ready;

   modport master (output i_readM, i_address, input i_data, i_ready);
   modport slave  (input i_readM, i_address, output i_data, i_ready);

endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer; built only when FETCH_BTB_EN is defined.
module fetch_btb #(
   parameter int WORD_SIZE   = 16,
   parameter int BTB_ENTRIES = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [WORD_SIZE-1:0] lookup_pc,
   output logic                 hit,
   output logic [WORD_SIZE-1:0] target,
   input  logic                 upd,
   input  logic [WORD_SIZE-1:0] upd_pc,
   input  logic [WORD_SIZE-1:0] upd_target
);

   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = WORD_SIZE - IDX_W;

   logic [BTB_ENTRIES-1:0]                valid_q;
   logic [BTB_ENTRIES-1:0][TAG_W-1:0]     tag_q;
   logic [BTB_ENTRIES-1:0][WORD_SIZE-1:0] tgt_q;
   logic [IDX_W-1:0]                      rd_idx, wr_idx;

   assign rd_idx = lookup_pc[IDX_W-1:0];
   assign wr_idx = upd_pc[IDX_W-1:0];

   // Reads see registered contents, so a same-cycle write returns the old entry.
   assign hit    = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_pc[WORD_SIZE-1:IDX_W]);
   assign target = tgt_q[rd_idx];

   always_ff @(posedge clk) begin
      if (reset_n)
         valid_q <= '0;
      else if (upd)
         valid_q[wr_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (upd) begin
         tag_q[wr_idx] <= upd_pc[WORD_SIZE-1:IDX_W];
         tgt_q[wr_idx] <= upd_target;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, memory handshake, two-deep output buffering, redirect squash.
// Optional BTB next-PC prediction is enabled with FETCH_BTB_EN.
module fetch_unit #(
   parameter int                   WORD_SIZE   = fetch_unit_pkg::WORD_SIZE,
   parameter logic [WORD_SIZE-1:0] RESET_PC    = WORD_SIZE'(fetch_unit_pkg::RESET_PC),
   parameter int                   BTB_ENTRIES = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   fetch_unit_if.master         mem,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   input  logic                 btb_update,
   input  logic [WORD_SIZE-1:0] btb_pc,
   input  logic [WORD_SIZE-1:0] btb_target,
   output logic [WORD_SIZE-1:0] inst_out,
   output logic [WORD_SIZE-1:0] pc_out,
   output logic [WORD_SIZE-1:0] pc_next_out,
   output logic                 isStall_out
);

   import fetch_unit_pkg::*;

   fetch_state_e         state, state_nxt;
   logic [WORD_SIZE-1:0] pc, disc_addr, nxt;
   logic                 out_valid, pend_valid, out_valid_nxt, pend_valid_nxt;
   logic [WORD_SIZE-1:0] out_inst, out_pc, out_pnext;
   logic [WORD_SIZE-1:0] pend_inst, pend_pc, pend_pnext;
   logic                 accept, out_free, out_ld, out_sel_pend, pend_ld;

`ifdef FETCH_BTB_EN
   logic                 btb_hit;
   logic [WORD_SIZE-1:0] btb_tgt;

   fetch_btb #(
      .WORD_SIZE   (WORD_SIZE),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .reset_n    (reset_n),
      .lookup_pc  (pc),
      .hit        (btb_hit),
      .target     (btb_tgt),
      .upd        (btb_update),
      .upd_pc     (btb_pc),
      .upd_target (btb_target)
   );

   assign nxt = btb_hit ? btb_tgt : pc + WORD_SIZE'(1);
`else
   logic unused_btb;
   assign unused_btb = ^{btb_update, btb_pc, btb_target, BTB_ENTRIES[0]};
   assign nxt        = pc + WORD_SIZE'(1);
`endif

   // DISCARD keeps presenting the abandoned request until memory answers it.
   assign mem.i_readM   = !reset_n && (state == FETCH || state == DISCARD);
   assign mem.i_address = (state == DISCARD) ? disc_addr : pc;

   assign accept   = (state == FETCH) && mem.i_ready;
   assign out_free = !out_valid || !stall;

   always_ff @(posedge clk) begin
      if (reset_n) state <= FETCH;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      out_valid_nxt  = out_valid;
      pend_valid_nxt = pend_valid;
      out_ld         = 1'b0;
      out_sel_pend   = 1'b0;
      pend_ld        = 1'b0;
      if (redirect) begin
         out_valid_nxt  = 1'b0;
         pend_valid_nxt = 1'b0;
         state_nxt      = (mem.i_readM && !mem.i_ready) ? DISCARD : FETCH;
      end else begin
         case (state)
            FETCH, FULL: begin
               if (out_free) begin
                  if (pend_valid) begin
                     out_ld         = 1'b1;
                     out_sel_pend   = 1'b1;
                     out_valid_nxt  = 1'b1;
                     pend_ld        = accept;
                     pend_valid_nxt = accept;
                  end else begin
                     out_ld        = accept;
                     out_valid_nxt = accept;
                  end
               end else if (accept && !pend_valid) begin
                  pend_ld        = 1'b1;
                  pend_valid_nxt = 1'b1;
               end
               state_nxt = (out_valid_nxt && pend_valid_nxt) ? FULL : FETCH;
            end
            DISCARD: if (mem.i_ready) state_nxt = FETCH;
            default: state_nxt = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         pc         <= RESET_PC;
         disc_addr  <= RESET_PC;
         out_valid  <= 1'b0;
         pend_valid <= 1'b0;
         out_inst   <= '0;
         out_pc     <= '0;
         out_pnext  <= '0;
         pend_inst  <= '0;
         pend_pc    <= '0;
         pend_pnext <= '0;
      end else begin
         out_valid  <= out_valid_nxt;
         pend_valid <= pend_valid_nxt;
         if (redirect) begin
            pc <= redirect_pc;
            if (state != DISCARD) disc_addr <= pc;
         end else if (accept) begin
            pc <= nxt;
         end
         if (out_ld) begin
            if (out_sel_pend) begin
               out_inst  <= pend_inst;
               out_pc    <= pend_pc;
               out_pnext <= pend_pnext;
            end else begin
               out_inst  <= mem.i_data;
               out_pc    <= pc;
               out_pnext <= nxt;
            end
         end
         if (pend_ld) begin
            pend_inst  <= mem.i_data;
            pend_pc    <= pc;
            pend_pnext <= nxt;
         end
      end
   end

   assign inst_out    = out_inst;
   assign pc_out      = out_pc;
   assign pc_next_out = out_pnext;
   assign isStall_out = !out_valid;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit pipelined CPU, directly upstream of the IF/ID pipeline latch. Holds the PC, runs the instruction-memory read handshake, buffers up to two fetched instructions across back-pressure, and drives the latch's `inst_in`/`pc_in`/`isStall_in` inputs. Squashes wrong-path fetches on a redirect from EX. An optional BTB supplies next-PC predictions.

## Interface
- `WORD_SIZE`, 16: datapath and address width (word-addressed memory).
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `BTB_ENTRIES`, 16: BTB depth, power of two. Used only with `FETCH_BTB_EN`.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-high reset, despite the name.
- `i_readM`  out  1  instruction read request.
- `i_address`  out  16  read address; stable while `i_readM` is high and `i_ready` is low.
- `i_data`  in  16  read data; valid only when `i_ready` is high.
- `i_ready`  in  1  one-cycle completion pulse for the outstanding request.
- `stall`  in  1  hazard unit holds IF/ID; the fetch output is not consumed.
- `redirect`  in  1  EX flush request (mispredict or jump).
- `redirect_pc`  in  16  correct next PC, valid with `redirect`.
- `btb_update`  in  1  BTB write strobe. Ignored without the macro.
- `btb_pc`  in  16  PC of the taken branch being written to the BTB.
- `btb_target`  in  16  target of that branch.
- `inst_out`  out  16  instruction to IF/ID.
- `pc_out`  out  16  PC of `inst_out`.
- `pc_next_out`  out  16  predicted next PC, carried down the pipe for the EX compare.
- `isStall_out`  out  1  1 = bubble (no valid instruction).

## Operation
- State: `pc`; output buffer (`out_*`, `out_valid`); pending buffer (`pend_*`, `pend_valid`); FSM {FETCH, FULL, DISCARD}.
- Reset: `pc`=`RESET_PC`; both buffers invalid; FSM=FETCH; `i_readM`=0 in the reset cycle.
- Reset output values: `inst_out`, `pc_out`, `pc_next_out` = 0; `isStall_out`=1.
- Fetch address: `i_address`=`pc`. Next PC: `nxt` = prediction with the macro, else `pc`+1 mod 2^16 (0xFFFF wraps to 0x0000).
- Consumption: the output buffer is consumed on every cycle with `stall`=0.
- FETCH: `i_readM`=1.
  - On `i_ready`, the word is placed by buffer state:
    - output buffer empty or consumed: load it.
    - otherwise, pending buffer empty: load the pending buffer.
  - On `i_ready`, `pc` <= `nxt`.
  - Transition to FULL when both buffers become valid.
- FULL: `i_readM`=0. On the first cycle with `stall`=0, pending moves to output, pending is cleared, and the FSM returns to FETCH.
- Redirect has priority over everything:
  - Both buffers are invalidated; `isStall_out`=1 from the next cycle.
  - `pc` <= `redirect_pc`.
  - Request outstanding without `i_ready` this cycle: go to DISCARD.
  - Otherwise (including `i_ready` in the same cycle, whose data is dropped): go to FETCH.
- DISCARD: `i_readM` and `i_address` are held at the old request; the returning data is dropped on `i_ready`; then FETCH at the new `pc`. A second redirect in DISCARD only overwrites `pc`.
- `redirect` together with `stall`: redirect wins (squash).

## Timing
- Earliest output: `i_ready` in cycle N gives a valid `inst_out` in N+1. Zero-wait memory (`i_ready` in the same cycle as the request) is legal.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Redirect in cycle N: bubble in N+1. The first new-path instruction appears at N+1+latency, plus one more cycle if the fetch went through DISCARD.
- All outputs are registered. `i_readM` and `i_address` derive from registered state only, never from `i_ready`.

## Configuration
- `FETCH_BTB_EN` defined:
  - Direct-mapped BTB with `BTB_ENTRIES` entries: valid bit, tag = `pc` above the index bits, 16-bit target.
  - Hit: `nxt` = target. Miss: `pc`+1.
  - Writes take effect on the next cycle.
  - Reset clears all valid bits.
  - A lookup in the same cycle as a write to the same index returns the old contents.
- Undefined: `nxt`=`pc`+1 always; `btb_*` inputs are ignored; no BTB storage is built.

## Structure
- Shared package/header: `WORD_SIZE`, `RESET_PC`, and the fetch FSM encoding (FETCH=0, FULL=1, DISCARD=2).
- Sub-module `fetch_btb` holds the BTB array and the lookup/update logic. It is instantiated only under `FETCH_BTB_EN`.

## Test plan
- Reset, then zero-wait memory returning 0x1111, 0x2222, …, no stall:
  - `pc_out` = 0, 1, 2… on consecutive cycles.
  - `isStall_out`=1 only in the first cycle after reset.
- Hold `stall` for 4 cycles mid-stream:
  - FULL is entered after two buffered words; `i_readM`=0.
  - On release, the output order is preserved with no loss or duplication.
- Redirect to 0x0040 while a 3-cycle memory is outstanding at 0x0005:
  - DISCARD entered; the returned word is dropped.
  - The next valid `pc_out`=0x0040.
- `redirect` and `i_ready` in the same cycle: the data is dropped and no DISCARD is entered.
- `pc`=0xFFFF: the next fetch address is 0x0000.
- With `FETCH_BTB_EN`: write `btb_pc`=0x0010 / `btb_target`=0x0030.
  - The next fetch of 0x0010 gives `pc_next_out`=0x0030, and the following fetch is at 0x0030.
  - Reset clears the entry.
